imem_loader: RTL and testbench

Boot-time program loader for the RV64I+Zba pipelined core. Accepts a byte stream over a valid/ready interface, assembles little-endian 32-bit instruction words and writes them sequentially into the instruction memory write port, holding the core in reset until the image is complete. It is the hardware writer that fills the instruction ROM the fetch stage reads, replacing file preload on FPGA builds.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/loader_word_asm.sv | 43 ++++
 rtl/imem_loader.sv | 173 +++++++++++++++++
 tb/tb_imem_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// The optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

    // Loader progress through the boot image
    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CHK,
        DONE,
        ERROR
    } loader_state_e;

    // Header is a little-endian word count
    localparam int HDR_BYTES      = 2;
    // Instruction words are assembled from this many stream bytes
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian word assembler: collects bytes into a 32-bit word and flags
// the byte that completes it. The completed word is presented combinationally
// alongside word_valid so the caller can register it on the same edge.
module loader_word_asm
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word_out
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] shift_q, shift_d;

    // Next byte index and shift contents; new bytes enter at the top so the
    // first byte of a word ends up in bits 7:0
    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (byte_en) begin
            idx_d   = idx_q + 2'd1;
            shift_d = {byte_in, shift_q[23:8]};
        end
    end

    assign word_valid = byte_en && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign word_out   = {byte_in, shift_q};

    // Byte index and partial-word storage; reset discards any partial word
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a byte stream (2-byte word count, then
// little-endian instruction words), writes the words sequentially into the
// instruction memory and holds the core in reset until the image is in.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    localparam int HDR_W = 8 * HDR_BYTES;

    loader_state_e     state_q, state_d;
    logic [HDR_W-1:0]  n_q, n_d;
    logic [HDR_W-1:0]  n_hdr;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              accept;
    logic              asm_en;
    logic              word_valid;
    logic [31:0]       word_out;
    logic              last_word;

    // Ready is gated by reset so nothing is accepted while the loader is held
    assign s_ready = rst && (state_q == HDR_LO || state_q == HDR_HI ||
                             state_q == DATA   || state_q == CHK);
    assign accept  = s_valid && s_ready;
    assign asm_en  = accept && (state_q == DATA);

    assign n_hdr     = {s_data, n_q[HDR_W-9:0]};
    assign last_word = (HDR_W'(word_cnt_q) + HDR_W'(1)) == n_q;

    loader_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_en    (asm_en),
        .byte_in    (s_data),
        .word_valid (word_valid),
        .word_out   (word_out)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Running XOR of every payload byte
    always_comb begin
        csum_d = csum_q;
        if (asm_en) begin
            csum_d = csum_q ^ s_data;
        end
    end

    // Checksum accumulator storage
    always_ff @(posedge clk) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // Next-state and output logic for the load sequence
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        word_cnt_d   = word_cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            HDR_LO: begin
                if (accept) begin
                    n_d     = {{(HDR_W - 8){1'b0}}, s_data};
                    state_d = HDR_HI;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    n_d = n_hdr;
                    if (n_hdr == '0 || n_hdr > HDR_W'(MAX_WORDS)) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_valid) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                    imem_wdata_d = word_out;
                    word_cnt_d   = word_cnt_q + 1'b1;
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    state_d = (s_data == csum_q) ? DONE : ERROR;
                end
            end
`endif
            default: begin
                // DONE and ERROR are terminal until reset
                state_d = state_q;
            end
        endcase

        // done trails entry into DONE by one cycle so the last write lands first
        done_d     = (state_q == DONE);
        core_rst_d = !done_d;
        error_d    = (state_d == ERROR);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= HDR_LO;
            n_q          <= '0;
            word_cnt_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_cnt_q   <= word_cnt_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a per-cycle vector table for the
// basic two-word load, plus hand-written sequences for header errors,
// gapped input, mid-load reset and (when compiled in) the checksum byte.
module tb_imem_loader;

    localparam int ADDR_W = 10;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'h00;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model filled from observed write strobes, sampled mid-cycle
    int          we_count = 0;
    logic [31:0] mem_model [0:1023];
    int          addr_log [$];

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            we_count++;
            mem_model[imem_addr] = imem_wdata;
            addr_log.push_back(int'(imem_addr));
            $display("write addr=%0d data=%08h", imem_addr, imem_wdata);
        end
    end

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic        dn;
        logic        er;
        logic        cr;
    } vec_t;

    vec_t vecs [$];

    logic [7:0] scen [0:9];
    logic [7:0] csum;

    function automatic vec_t mk(logic v, logic [7:0] d, logic rdy, logic we,
                                logic [9:0] addr, logic [31:0] wd,
                                logic dn, logic er, logic cr);
        vec_t r;
        r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.addr = addr;
        r.wd = wd; r.dn = dn; r.er = er; r.cr = cr;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic send(input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check({nm, " rst s_ready"},    32'(s_ready),    32'd0);
        check({nm, " rst imem_we"},    32'(imem_we),    32'd0);
        check({nm, " rst imem_addr"},  32'(imem_addr),  32'd0);
        check({nm, " rst imem_wdata"}, imem_wdata,      32'd0);
        check({nm, " rst core_rst"},   32'(core_rst),   32'd1);
        check({nm, " rst done"},       32'(done),       32'd0);
        check({nm, " rst error"},      32'(error),      32'd0);
        we_count = 0;
        addr_log.delete();
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'hdead_beef;
        rst = 1'b1;
    endtask

    initial begin
        scen[0] = 8'h02; scen[1] = 8'h00;
        scen[2] = 8'h13; scen[3] = 8'h05; scen[4] = 8'ha0; scen[5] = 8'h00;
        scen[6] = 8'h93; scen[7] = 8'h05; scen[8] = 8'hb0; scen[9] = 8'h00;
        csum = 8'h00;
        for (int i = 2; i < 10; i++) csum = csum ^ scen[i];

        // Scenario 1 as a per-cycle table; expectations are post-edge values
        vecs.push_back(mk(1, 8'h02, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'h13, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'h05, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'ha0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'h00, 1, 1, 0, 32'h00a00513, 0, 0, 1));
        vecs.push_back(mk(1, 8'h93, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'h05, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'hb0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'h00, CHK_ON, 1, 1, 32'h00b00593, 0, 0, 1));
        if (CHK_ON) begin
            vecs.push_back(mk(1, csum,  0, 0, 0, 0, 0, 0, 1));
            vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0));
        end else begin
            vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0));
        end
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0));

        // ---- Scenario 1: table driven ----
        do_reset("s1");
        for (int i = 0; i < vecs.size(); i++) begin
            s_valid = vecs[i].v;
            s_data  = vecs[i].d;
            @(posedge clk);
            #1;
            check($sformatf("s1 row%0d s_ready", i),  32'(s_ready),  32'(vecs[i].rdy));
            check($sformatf("s1 row%0d imem_we", i),  32'(imem_we),  32'(vecs[i].we));
            check($sformatf("s1 row%0d done", i),     32'(done),     32'(vecs[i].dn));
            check($sformatf("s1 row%0d error", i),    32'(error),    32'(vecs[i].er));
            check($sformatf("s1 row%0d core_rst", i), 32'(core_rst), 32'(vecs[i].cr));
            if (vecs[i].we) begin
                check($sformatf("s1 row%0d imem_addr", i),  32'(imem_addr), 32'(vecs[i].addr));
                check($sformatf("s1 row%0d imem_wdata", i), imem_wdata,     vecs[i].wd);
            end
        end
        s_valid = 1'b0;
        // DONE is terminal: further offered bytes are neither accepted nor written
        s_valid = 1'b1;
        s_data  = 8'hff;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("s1 we_count",   32'(we_count), 32'd2);
        check("s1 mem0",       mem_model[0],  32'h00a00513);
        check("s1 mem1",       mem_model[1],  32'h00b00593);
        check("s1 done stuck", 32'(done),     32'd1);

        // ---- Header N=0 ----
        do_reset("n0");
        send(8'h00);
        check("n0 error after lo", 32'(error), 32'd0);
        send(8'h00);
        check("n0 error",    32'(error),    32'd1);
        check("n0 s_ready",  32'(s_ready),  32'd0);
        check("n0 core_rst", 32'(core_rst), 32'd1);
        send(8'h13);
        idle();
        idle();
        check("n0 error sticky", 32'(error),    32'd1);
        check("n0 done",         32'(done),     32'd0);
        check("n0 core_rst2",    32'(core_rst), 32'd1);
        check("n0 we_count",     32'(we_count), 32'd0);

        // ---- Header N=1025 ----
        do_reset("nbig");
        send(8'h01);
        send(8'h04);
        check("nbig error",   32'(error),   32'd1);
        check("nbig s_ready", 32'(s_ready), 32'd0);
        for (int i = 0; i < 4; i++) send(8'h11);
        check("nbig we_count", 32'(we_count), 32'd0);
        check("nbig core_rst", 32'(core_rst), 32'd1);

        // ---- Scenario 1 with a garbage idle cycle before every byte ----
        do_reset("gap");
        for (int i = 0; i < 10; i++) begin
            idle();
            send(scen[i]);
        end
        if (CHK_ON) begin
            idle();
            send(csum);
        end
        check("gap done at +1", 32'(done), 32'd0);
        idle();
        check("gap done at +2",     32'(done),     32'd1);
        check("gap core_rst at +2", 32'(core_rst), 32'd0);
        check("gap we_count",       32'(we_count), 32'd2);
        check("gap mem0",           mem_model[0],  32'h00a00513);
        check("gap mem1",           mem_model[1],  32'h00b00593);

        // ---- Reset after 5 payload bytes, then a full reload ----
        do_reset("abort");
        for (int i = 0; i < 7; i++) send(scen[i]);
        check("abort pre we_count", 32'(we_count), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort rst s_ready",  32'(s_ready),  32'd0);
        check("abort rst core_rst", 32'(core_rst), 32'd1);
        check("abort rst imem_we",  32'(imem_we),  32'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) send(scen[i]);
        if (CHK_ON) send(csum);
        idle();
        idle();
        check("abort we_count",  32'(we_count), 32'd3);
        check("abort addr1",     32'(addr_log.size() > 1 ? addr_log[1] : -1), 32'd0);
        check("abort addr2",     32'(addr_log.size() > 2 ? addr_log[2] : -1), 32'd1);
        check("abort mem0",      mem_model[0],  32'h00a00513);
        check("abort mem1",      mem_model[1],  32'h00b00593);
        check("abort done",      32'(done),     32'd1);
        check("abort core_rst",  32'(core_rst), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // ---- Wrong checksum ----
        do_reset("badck");
        for (int i = 0; i < 10; i++) send(scen[i]);
        check("badck s_ready in CHK", 32'(s_ready), 32'd1);
        send(csum ^ 8'h01);
        check("badck error",   32'(error),   32'd1);
        check("badck s_ready", 32'(s_ready), 32'd0);
        idle();
        idle();
        check("badck core_rst", 32'(core_rst), 32'd1);
        check("badck done",     32'(done),     32'd0);
        check("badck we_count", 32'(we_count), 32'd2);
        check("badck mem1",     mem_model[1],  32'h00b00593);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
